// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//
// Purpose: accepts one load/store request at a time from the execute stage
// and sequences it onto a single-port, registered-output data RAM. Word-crossing
// accesses are split into two aligned RAM accesses. Load data from the two
// words is merged, shifted down and sign/zero-extended. A single-cycle response
// returns the destination tag.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready - request handshake; transfer when both are high
//   req_store           - 1 = store, 0 = load
//   req_funct3          - RISC-V size/sign code
//   req_addr            - byte address (bits above RAM_AW+1 ignored)
//   req_wdata           - right-justified store data
//   req_rd              - destination tag, echoed on rsp_rd
//   rsp_valid           - one-cycle response pulse
//   rsp_rdata           - extended load data (0 for stores and errors)
//   rsp_rd              - tag of the completed request
//   rsp_err             - illegal funct3 for the access type
//   ram_addr            - RAM word address
//   ram_byteen          - RAM byte-lane enables
//   ram_wdata           - RAM write data
//   ram_wren            - RAM write enable
//   ram_rdata           - RAM read data, valid one cycle after the address
module mem_access_sequencer #(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Loads accept only 000/001/010/100/101; stores only 000/001/010.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        logic bad;
        if (store) begin
            bad = f3[2] || (f3 == 3'b011);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    // Sign- or zero-extend the low bytes of a merged load word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] x);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{x[7]}}, x[7:0]};
            3'b001:  r = {{16{x[15]}}, x[15:0]};
            3'b100:  r = {24'd0, x[7:0]};
            3'b101:  r = {16'd0, x[15:0]};
            default: r = x;
        endcase
        return r;
    endfunction

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [RAM_AW+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [31:0]       hold_q, hold_d;
    logic [RAM_AW-1:0] last_addr_q, last_addr_d;
    logic [31:0]       last_wdata_q, last_wdata_d;

    logic              accept_s;
    logic [7:0]        size_mask_s;
    logic [7:0]        lane_mask_s;
    logic              split_s;
    logic [63:0]       store_data_s;
    logic [RAM_AW-1:0] word_lo_s;
    logic [RAM_AW-1:0] word_hi_s;
    logic [31:0]       lo_word_s;
    logic [31:0]       hi_word_s;
    logic [31:0]       merged_s;

    logic              req_ready_s;
    logic              rsp_valid_s;
    logic [31:0]       rsp_rdata_s;
    logic [4:0]        rsp_rd_s;
    logic              rsp_err_s;
    logic [RAM_AW-1:0] ram_addr_s;
    logic [3:0]        ram_byteen_s;
    logic [31:0]       ram_wdata_s;
    logic              ram_wren_s;

    // Lane mask, split decision, shifted store data and merged load data.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_mask_s = 8'h01;
            2'b01:   size_mask_s = 8'h03;
            default: size_mask_s = 8'h0F;
        endcase
        lane_mask_s  = size_mask_s << addr_q[1:0];
        split_s      = |lane_mask_s[7:4];
        store_data_s = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
        word_lo_s    = addr_q[RAM_AW+1:2];
        // Natural wrap of the word counter handles the top-of-RAM crossing.
        word_hi_s    = word_lo_s + {{(RAM_AW-1){1'b0}}, 1'b1};
        // In DONE ram_rdata is the high word for split accesses, else the low word.
        if (split_s) begin
            lo_word_s = hold_q;
            hi_word_s = ram_rdata;
        end else begin
            lo_word_s = ram_rdata;
            hi_word_s = 32'd0;
        end
        merged_s = 32'({hi_word_s, lo_word_s} >> {addr_q[1:0], 3'b000});
    end

    // Next-state logic and request/holding register updates.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        err_d        = err_q;
        hold_d       = hold_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;
        accept_s     = req_valid && req_ready_s;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[RAM_AW+1:0];
                    wdata_d  = req_wdata;
                    rd_d     = req_rd;
                    err_d    = f3_illegal(req_store, req_funct3);
                    state_d  = f3_illegal(req_store, req_funct3) ? S_DONE : S_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                last_addr_d  = ram_addr_s;
                last_wdata_d = ram_wdata_s;
                state_d      = split_s ? S_HI : S_DONE;
            end
            S_HI: begin
                last_addr_d  = ram_addr_s;
                last_wdata_d = ram_wdata_s;
                hold_d       = ram_rdata;
                state_d      = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and the registered request.
    always_comb begin
        req_ready_s  = (state_q == S_IDLE);
        rsp_valid_s  = 1'b0;
        rsp_rdata_s  = 32'd0;
        rsp_rd_s     = 5'd0;
        rsp_err_s    = 1'b0;
        ram_addr_s   = last_addr_q;
        ram_byteen_s = 4'd0;
        ram_wdata_s  = last_wdata_q;
        ram_wren_s   = 1'b0;
        case (state_q)
            S_LO: begin
                ram_addr_s   = word_lo_s;
                ram_byteen_s = lane_mask_s[3:0];
                ram_wdata_s  = store_data_s[31:0];
                ram_wren_s   = store_q;
            end
            S_HI: begin
                ram_addr_s   = word_hi_s;
                ram_byteen_s = lane_mask_s[7:4];
                ram_wdata_s  = store_data_s[63:32];
                ram_wren_s   = store_q;
            end
            S_DONE: begin
                rsp_valid_s = 1'b1;
                rsp_rd_s    = rd_q;
                rsp_err_s   = err_q;
                if (err_q || store_q) begin
                    rsp_rdata_s = 32'd0;
                end else begin
                    rsp_rdata_s = load_extend(funct3_q, merged_s);
                end
            end
            default: begin
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // Reset forces every output quiet immediately, not only after the edge.
    assign req_ready  = req_ready_s && !rst;
    assign rsp_valid  = rsp_valid_s && !rst;
    assign rsp_rdata  = rst ? 32'd0 : rsp_rdata_s;
    assign rsp_rd     = rst ? 5'd0 : rsp_rd_s;
    assign rsp_err    = rsp_err_s && !rst;
    assign ram_addr   = rst ? {RAM_AW{1'b0}} : ram_addr_s;
    assign ram_byteen = rst ? 4'd0 : ram_byteen_s;
    assign ram_wdata  = rst ? 32'd0 : ram_wdata_s;
    assign ram_wren   = ram_wren_s && !rst;

    // State, request and holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= {(RAM_AW+2){1'b0}};
            wdata_q      <= 32'd0;
            rd_q         <= 5'd0;
            err_q        <= 1'b0;
            hold_q       <= 32'd0;
            last_addr_q  <= {RAM_AW{1'b0}};
            last_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
            hold_q       <= hold_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: directed vector table, a reset-during-HI
// sequence, and random traffic checked against a byte-array memory model.
module tb_mem_access_sequencer;

    localparam int RAM_AW = 10;
    localparam int WORDS  = 1 << RAM_AW;
    localparam int BYTES  = 4 * WORDS;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [4:0]        rsp_rd;
    logic              rsp_err;
    logic [RAM_AW-1:0] ram_addr;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_wdata;
    logic              ram_wren;
    logic [31:0]       ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [WORDS];
    logic [7:0]  model_mem [BYTES];

    logic [3:0]        tr_be   [0:9];
    logic [RAM_AW-1:0] tr_addr [0:9];
    logic [31:0]       tr_wd   [0:9];
    logic              tr_wren [0:9];

    mem_access_sequencer #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err), .ram_addr(ram_addr),
        .ram_byteen(ram_byteen), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Registered single-port RAM with byte enables.
    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic init_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int b = 0; b < 4; b++) model_mem[4*w + b] = v[8*b +: 8];
    endtask

    // Reference model: byte-addressed memory, little-endian, wrapping.
    task automatic model_exec(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] e_rdata,
                              output logic e_err, output int e_lat);
        int n, off, ba;
        logic [31:0] v;
        logic bad;
        bad = st ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        n   = 1 << f3[1:0];
        off = int'(a[1:0]);
        ba  = int'(a % BYTES);
        e_rdata = 32'd0;
        e_err   = bad;
        if (bad) begin
            e_lat = 1;
        end else begin
            e_lat = (off + n > 4) ? 3 : 2;
            if (st) begin
                for (int i = 0; i < n; i++) model_mem[(ba + i) % BYTES] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[(ba + i) % BYTES];
                if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
                e_rdata = v;
            end
        end
    endtask

    // Issue one request starting at a negedge; returns at the response negedge.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic [31:0] o_rdata, output logic o_err,
                          output logic [4:0] o_rd, output int o_lat);
        int waitc;
        int cyc;
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        waitc = 0;
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: req_ready stayed 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs to show the request was latched.
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom); req_rd = 5'($urandom); req_store = 1'($urandom);
        o_lat = 0; o_rdata = 32'd0; o_err = 1'b0; o_rd = 5'd0;
        for (int k = 0; k < 10; k++) begin
            tr_be[k] = 4'd0; tr_addr[k] = '0; tr_wd[k] = 32'd0; tr_wren[k] = 1'b0;
        end
        cyc = 1;
        while (cyc <= 8) begin
            tr_be[cyc] = ram_byteen; tr_addr[cyc] = ram_addr;
            tr_wd[cyc] = ram_wdata;  tr_wren[cyc] = ram_wren;
            if (rsp_valid) begin
                o_lat = cyc; o_rdata = rsp_rdata; o_err = rsp_err; o_rd = rsp_rd;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          kind;   // 0 none, 1 LW trace, 2 split SW trace, 3 no RAM activity
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] g_rdata, m_rdata, expw;
        logic g_err, m_err;
        logic [4:0] g_rd;
        int g_lat, m_lat;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd;
        logic [4:0] rd;

        tbl[0] = '{1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd1, 32'h8899_AABB, 1'b0, 2, 1};
        tbl[1] = '{1'b0, 3'b000, 32'h0000_0023, 32'd0, 5'd2, 32'hFFFF_FF80, 1'b0, 2, 0};
        tbl[2] = '{1'b0, 3'b100, 32'h0000_0023, 32'd0, 5'd3, 32'h0000_0080, 1'b0, 2, 0};
        tbl[3] = '{1'b1, 3'b010, 32'h0000_0016, 32'hDEAD_BEEF, 5'd4, 32'd0, 1'b0, 3, 2};
        tbl[4] = '{1'b0, 3'b010, 32'h0000_0016, 32'd0, 5'd5, 32'hDEAD_BEEF, 1'b0, 3, 0};
        tbl[5] = '{1'b0, 3'b001, 32'h0000_0FFF, 32'd0, 5'd6, 32'hFFFF_CDAB, 1'b0, 3, 0};
        tbl[6] = '{1'b0, 3'b111, 32'h0000_0010, 32'd0, 5'd7, 32'd0, 1'b1, 1, 3};
        tbl[7] = '{1'b1, 3'b100, 32'h0000_0010, 32'h1111_1111, 5'd8, 32'd0, 1'b1, 1, 3};
        tbl[8] = '{1'b0, 3'b101, 32'hFFFF_F011, 32'd0, 5'd9, 32'h0000_99AA, 1'b0, 2, 0};
        tbl[9] = '{1'b0, 3'b001, 32'h0000_0013, 32'd0, 5'd31, 32'h0000_0088, 1'b0, 3, 0};

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        for (int w = 0; w < WORDS; w++) init_word(w, 32'd0);
        init_word(4, 32'h8899_AABB);
        init_word(8, 32'h8011_2233);
        init_word(WORDS - 1, 32'hAB00_0000);
        init_word(0, 32'h0000_00CD);

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_wren", {31'd0, ram_wren}, 32'd0);
        chk("rst_byteen", {28'd0, ram_byteen}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            model_exec(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, m_rdata, m_err, m_lat);
            do_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd, g_rdata, g_err, g_rd, g_lat);
            chk($sformatf("tbl%0d_rdata", i), g_rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_err", i), {31'd0, g_err}, {31'd0, tbl[i].e_err});
            chk($sformatf("tbl%0d_rd", i), {27'd0, g_rd}, {27'd0, tbl[i].rd});
            chk($sformatf("tbl%0d_lat", i), g_lat, tbl[i].e_lat);
            case (tbl[i].kind)
                1: begin
                    chk("lw_addr", {22'd0, tr_addr[1]}, 32'd4);
                    chk("lw_be", {28'd0, tr_be[1]}, 32'hF);
                    chk("lw_wren", {31'd0, tr_wren[1]}, 32'd0);
                end
                2: begin
                    chk("sw_lo_addr", {22'd0, tr_addr[1]}, 32'd5);
                    chk("sw_lo_be", {28'd0, tr_be[1]}, 32'hC);
                    chk("sw_lo_wd", {16'd0, tr_wd[1][31:16]}, 32'hBEEF);
                    chk("sw_lo_wren", {31'd0, tr_wren[1]}, 32'd1);
                    chk("sw_hi_addr", {22'd0, tr_addr[2]}, 32'd6);
                    chk("sw_hi_be", {28'd0, tr_be[2]}, 32'h3);
                    chk("sw_hi_wd", {16'd0, tr_wd[2][15:0]}, 32'hDEAD);
                    chk("sw_hi_wren", {31'd0, tr_wren[2]}, 32'd1);
                end
                3: begin
                    chk("ill_be", {28'd0, tr_be[1]}, 32'd0);
                    chk("ill_wren", {31'd0, tr_wren[1]}, 32'd0);
                end
                default: ;
            endcase
        end

        // Split SH to 0x2F with reset asserted during HI.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h0000_002F; req_wdata = 32'h0000_1234; req_rd = 5'd10;
        chk("rsth_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsth_lo_be", {28'd0, ram_byteen}, 32'h8);
        chk("rsth_lo_wren", {31'd0, ram_wren}, 32'd1);
        @(negedge clk);
        chk("rsth_hi_be", {28'd0, ram_byteen}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rsth_wren", {31'd0, ram_wren}, 32'd0);
        chk("rsth_byteen", {28'd0, ram_byteen}, 32'd0);
        chk("rsth_ready", {31'd0, req_ready}, 32'd0);
        chk("rsth_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rsth_ready_after", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rsth_no_rsp%0d", k), {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("rsth_lo_word", mem[11], 32'h3400_0000);
        chk("rsth_hi_word", mem[12], 32'd0);
        model_mem[8'h2F] = 8'h34;

        // Random traffic, mostly in a small window so loads see prior stores.
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = ($urandom & 32'hFFFF_F000) | 32'h0000_0FFC | ($urandom & 32'h3);
            else a = $urandom & 32'hFFFF_F03F;
            wd = $urandom;
            rd = 5'($urandom);
            model_exec(st, f3, a, wd, m_rdata, m_err, m_lat);
            do_req(st, f3, a, wd, rd, g_rdata, g_err, g_rd, g_lat);
            chk($sformatf("rnd%0d_rdata", i), g_rdata, m_rdata);
            chk($sformatf("rnd%0d_err", i), {31'd0, g_err}, {31'd0, m_err});
            chk($sformatf("rnd%0d_rd", i), {27'd0, g_rd}, {27'd0, rd});
            chk($sformatf("rnd%0d_lat", i), g_lat, m_lat);
        end

        @(negedge clk);
        for (int w = 0; w < WORDS; w++) begin
            expw = {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]};
            chk($sformatf("mem_word%0d", w), mem[w], expw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
